cart_sram_backup: RTL and testbench

Battery-backed SRAM persistence engine for the cartridge slot. It moves the 8 KB mapper SRAM to and from the MiSTer SD save image, one 512-byte sector at a time. It is the reading end of the SRAM that the ASCII16/ASCII8 mappers write through `sram_we`. It connects between the SRAM's second BRAM port and the hps_io SD block interface.

---
 rtl/cart_sram_backup.sv | 151 +++++++++++++++
 tb/tb_cart_sram_backup.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_sram_backup.sv
// Battery-backed SRAM persistence engine: streams the 8 KB mapper SRAM to and
// from the SD save image one 512-byte sector at a time through hps_io.
module cart_sram_backup #(
   parameter int SECTORS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        img_mounted,
   input  logic [63:0] img_size,
   input  logic        save_req,
   input  logic        mapper_sram_we,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   input  logic [8:0]  sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   output logic [7:0]  sd_buff_din,
   input  logic        sd_buff_wr,
   output logic [12:0] sram_b_addr,
   output logic [7:0]  sram_b_din,
   output logic        sram_b_we,
   input  logic [7:0]  sram_b_dout,
   output logic        busy,
   output logic        dirty
);

   localparam logic [3:0] LAST_MAX = 4'(SECTORS - 1);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER} state_t;

   state_t      state, state_n;
   logic [3:0]  sec, sec_n, last, last_n;
   logic [3:0]  img_last, mount_last;
   logic [54:0] img_sectors;
   logic        load_pend, save_pend, mounted, ack_q;
   logic        load_start, save_start, load_done;
   logic        big_image, ack_fall;

   assign img_sectors = img_size[63:9];
   assign big_image   = (img_size >= 64'd512);
   assign ack_fall    = ack_q & ~sd_ack;

   // Image length in sectors, clamped to the SRAM size, as a last-sector index.
   always_comb begin
      mount_last = LAST_MAX;
      if (img_sectors < 55'(SECTORS))
         mount_last = img_sectors[3:0] - 4'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sec   <= 4'd0;
         last  <= LAST_MAX;
         ack_q <= 1'b0;
      end else begin
         state <= state_n;
         sec   <= sec_n;
         last  <= last_n;
         ack_q <= sd_ack;
      end
   end

   always_comb begin
      state_n    = state;
      sec_n      = sec;
      last_n     = last;
      load_start = 1'b0;
      save_start = 1'b0;
      load_done  = 1'b0;
      case (state)
         IDLE: begin
            if (load_pend) begin
               load_start = 1'b1;
               sec_n      = 4'd0;
               last_n     = img_last;
               state_n    = RD_REQ;
            end else if (save_pend) begin
               save_start = 1'b1;
               sec_n      = 4'd0;
               last_n     = LAST_MAX;
               state_n    = WR_REQ;
            end
         end
         RD_REQ:  if (sd_ack) state_n = RD_XFER;
         WR_REQ:  if (sd_ack) state_n = WR_XFER;
         RD_XFER: begin
            if (ack_fall) begin
               if (sec == last) begin
                  load_done = 1'b1;
                  state_n   = IDLE;
               end else begin
                  sec_n   = sec + 4'd1;
                  state_n = RD_REQ;
               end
            end
         end
         WR_XFER: begin
            if (ack_fall) begin
               if (sec == last) begin
                  state_n = IDLE;
               end else begin
                  sec_n   = sec + 4'd1;
                  state_n = WR_REQ;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Pending requests and the dirty flag; a mapper write always wins over a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_pend <= 1'b0;
         save_pend <= 1'b0;
         mounted   <= 1'b0;
         dirty     <= 1'b0;
         img_last  <= LAST_MAX;
      end else begin
         if (load_start)
            load_pend <= 1'b0;
         if (save_start)
            save_pend <= 1'b0;
         if (img_mounted) begin
            mounted <= big_image;
            if (big_image) begin
               load_pend <= 1'b1;
               img_last  <= mount_last;
            end
         end
         if (save_req && dirty && mounted)
            save_pend <= 1'b1;
         if (mapper_sram_we)
            dirty <= 1'b1;
         else if (save_start || load_done || (img_mounted && !big_image))
            dirty <= 1'b0;
      end
   end

   assign sd_lba      = {28'd0, sec};
   assign sd_rd       = (state == RD_REQ);
   assign sd_wr       = (state == WR_REQ);
   assign sram_b_addr = {sec, sd_buff_addr};
   assign sd_buff_din = sram_b_dout;
   assign sram_b_din  = sd_buff_dout;
   assign sram_b_we   = sd_buff_wr & sd_ack & (state == RD_XFER);
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_cart_sram_backup.sv
// Bench for cart_sram_backup: an HPS sector-buffer model, an SRAM port-B model
// and a byte-level model of what the SRAM and the save image must contain.
module tb_cart_sram_backup;

   logic        clk;
   logic        reset;
   logic        img_mounted;
   logic [63:0] img_size;
   logic        save_req;
   logic        mapper_sram_we;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout, sd_buff_din;
   logic        sd_buff_wr;
   logic [12:0] sram_b_addr;
   logic [7:0]  sram_b_din, sram_b_dout;
   logic        sram_b_we;
   logic        busy, dirty;

   int tests = 0;
   int fails = 0;

   logic [7:0] mem     [0:8191];
   logic [7:0] ref_mem [0:8191];
   logic [7:0] cap_mem [0:8191];
   logic [7:0] sram_rdata;

   int         rd_lbas[$];
   int         wr_lbas[$];
   int         cap_cnt = 0;
   logic [7:0] hps_salt;
   logic       hps_xfer = 1'b0;
   logic       hps_is_rd = 1'b0;
   logic [3:0] hps_sec = 4'd0;
   int         hps_byte = 0;

   cart_sram_backup #(.SECTORS(16)) dut (
      .clk(clk), .reset(reset),
      .img_mounted(img_mounted), .img_size(img_size),
      .save_req(save_req), .mapper_sram_we(mapper_sram_we),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
      .sram_b_addr(sram_b_addr), .sram_b_din(sram_b_din),
      .sram_b_we(sram_b_we), .sram_b_dout(sram_b_dout),
      .busy(busy), .dirty(dirty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM port B: synchronous write, one-cycle read latency.
   assign sram_b_dout = sram_rdata;
   always @(posedge clk) begin
      if (sram_b_we)
         mem[sram_b_addr] <= sram_b_din;
      sram_rdata <= mem[sram_b_addr];
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic mnt, input logic [63:0] size, input logic sv, input logic we);
      @(negedge clk);
      img_mounted = mnt;
      if (mnt)
         img_size = size;
      save_req       = sv;
      mapper_sram_we = we;
      @(negedge clk);
      img_mounted    = 1'b0;
      save_req       = 1'b0;
      mapper_sram_we = 1'b0;
   endtask

   task automatic waitUntilDone(input string name, input int n_rd, input int n_wr, input int budget);
      int cyc = 0;
      while (!(rd_lbas.size() >= n_rd && wr_lbas.size() >= n_wr && !busy && !hps_xfer) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({name, "_timeout"}, 64'(cyc >= budget), 64'd0);
   endtask

   task automatic waitSector(input string name, input logic is_rd, input int n_req, input int min_byte, input int budget);
      int cyc = 0;
      while (!((is_rd ? rd_lbas.size() : wr_lbas.size()) == n_req && hps_xfer && hps_byte >= min_byte) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({name, "_timeout"}, 64'(cyc >= budget), 64'd0);
   endtask

   task automatic checkLbas(input string name, input int q[$], input int base, input int n);
      int bad = 0;
      checkOutput({name, "_count"}, 64'(q.size() - base), 64'(n));
      for (int i = base; i < q.size(); i++)
         if (q[i] != (i - base) % 16) bad++;
      checkOutput({name, "_seq"}, 64'(bad), 64'd0);
   endtask

   function automatic int memErrors();
      int n = 0;
      for (int i = 0; i < 8192; i++)
         if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   function automatic int capErrors();
      int n = 0;
      for (int i = 0; i < 8192; i++)
         if (cap_mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   // HPS side: acknowledge each request, then stream 512 bytes in or out.
   initial begin : hps
      logic [31:0] lba;
      logic        is_rd;
      logic [12:0] idx;
      logic [7:0]  b;
      sd_ack       = 1'b0;
      sd_buff_addr = 9'd0;
      sd_buff_dout = 8'd0;
      sd_buff_wr   = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && (sd_rd || sd_wr)) begin
            is_rd = sd_rd;
            lba   = sd_lba;
            if (is_rd) rd_lbas.push_back(int'(lba));
            else       wr_lbas.push_back(int'(lba));
            @(negedge clk);
            checkOutput("req_hold", 64'(is_rd ? sd_rd : sd_wr), 64'd1);
            sd_ack    = 1'b1;
            hps_is_rd = is_rd;
            hps_sec   = lba[3:0];
            hps_byte  = 0;
            hps_xfer  = 1'b1;
            @(negedge clk);
            checkOutput("req_drop", 64'(sd_rd | sd_wr), 64'd0);
            for (int a = 0; a < 512 && !reset; a++) begin
               hps_byte     = a;
               idx          = {lba[3:0], 9'(a)};
               sd_buff_addr = 9'(a);
               if (is_rd) begin
                  b            = lba[7:0] ^ 8'(a) ^ hps_salt;
                  sd_buff_dout = b;
                  sd_buff_wr   = 1'b1;
                  @(negedge clk);
                  if (!reset) ref_mem[idx] = b;
               end else begin
                  @(negedge clk);
                  @(negedge clk);
                  if (!reset) begin
                     cap_mem[idx] = sd_buff_din;
                     cap_cnt++;
                  end
               end
            end
            sd_buff_wr = 1'b0;
            sd_ack     = 1'b0;
            hps_xfer   = 1'b0;
         end
      end
   end

   // Per-cycle checks of the data paths and request/busy consistency.
   initial begin : compare
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            checkOutput("din_path", 64'(sram_b_din), 64'(sd_buff_dout));
            checkOutput("dout_path", 64'(sd_buff_din), 64'(sram_rdata));
            checkOutput("sram_we", 64'(sram_b_we), 64'(hps_xfer && hps_is_rd && sd_buff_wr));
            if (hps_xfer)
               checkOutput("sram_addr", 64'(sram_b_addr), 64'({hps_sec, sd_buff_addr}));
            if (hps_xfer || sd_rd || sd_wr)
               checkOutput("busy_xfer", 64'(busy), 64'd1);
            checkOutput("rd_wr_excl", 64'(sd_rd & sd_wr), 64'd0);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int base_rd, base_wr, base_cap;
      logic seen;
      reset          = 1'b1;
      img_mounted    = 1'b0;
      img_size       = 64'd0;
      save_req       = 1'b0;
      mapper_sram_we = 1'b0;
      hps_salt       = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rst_lba", 64'(sd_lba), 64'd0);
      checkOutput("rst_rd", 64'(sd_rd), 64'd0);
      checkOutput("rst_wr", 64'(sd_wr), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_dirty", 64'(dirty), 64'd0);
      checkOutput("rst_we", 64'(sram_b_we), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Full 8 KB load with the plain sec^addr pattern.
      base_rd = rd_lbas.size();
      applyStimulus(1'b1, 64'd8192, 1'b0, 1'b0);
      checkOutput("lat_early", 64'(sd_rd), 64'd0);
      @(negedge clk);
      checkOutput("lat_rd", 64'(sd_rd), 64'd1);
      checkOutput("lat_lba", 64'(sd_lba), 64'd0);
      waitUntilDone("load", base_rd + 16, 0, 20000);
      checkLbas("load_lba", rd_lbas, base_rd, 16);
      checkOutput("load_mem", 64'(memErrors()), 64'd0);
      checkOutput("load_pin_205", 64'(mem[13'h0205]), 64'h04);
      checkOutput("load_pin_1e34", 64'(mem[13'h1E34]), 64'h3B);
      checkOutput("load_pin_1fff", 64'(mem[13'h1FFF]), 64'hF0);
      checkOutput("load_dirty", 64'(dirty), 64'd0);
      checkOutput("load_busy", 64'(busy), 64'd0);

      // Save request while clean must be ignored.
      base_wr = wr_lbas.size();
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | sd_wr | busy;
      end
      checkOutput("clean_save_quiet", 64'(seen), 64'd0);
      checkOutput("clean_save_count", 64'(wr_lbas.size() - base_wr), 64'd0);

      // Short image: two sectors, salted so untouched SRAM is distinguishable.
      base_rd  = rd_lbas.size();
      hps_salt = 8'hA5;
      applyStimulus(1'b1, 64'd1024, 1'b0, 1'b0);
      waitUntilDone("short", base_rd + 2, 0, 5000);
      checkLbas("short_lba", rd_lbas, base_rd, 2);
      checkOutput("short_mem", 64'(memErrors()), 64'd0);
      checkOutput("short_pin_3", 64'(mem[13'h0003]), 64'hA6);
      checkOutput("short_pin_201", 64'(mem[13'h0201]), 64'hA5);
      checkOutput("short_pin_400", 64'(mem[13'h0400]), 64'h02);

      // Save with a mapper write during sector 7: dirty survives the save.
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
      checkOutput("dirty_set", 64'(dirty), 64'd1);
      base_wr  = wr_lbas.size();
      base_cap = cap_cnt;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      waitSector("save_s7", 1'b0, base_wr + 8, 0, 20000);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
      waitUntilDone("save", 0, base_wr + 16, 30000);
      checkLbas("save_lba", wr_lbas, base_wr, 16);
      checkOutput("save_cap_cnt", 64'(cap_cnt - base_cap), 64'd8192);
      checkOutput("save_cap", 64'(capErrors()), 64'd0);
      checkOutput("save_pin_201", 64'(cap_mem[13'h0201]), 64'hA5);
      checkOutput("save_pin_1fff", 64'(cap_mem[13'h1FFF]), 64'hF0);
      checkOutput("save_dirty", 64'(dirty), 64'd1);
      checkOutput("save_busy", 64'(busy), 64'd0);

      // Repeated save requests while busy merge into exactly one follow-up save.
      base_wr  = wr_lbas.size();
      base_cap = cap_cnt;
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      waitSector("resave_s2", 1'b0, base_wr + 3, 0, 20000);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      waitUntilDone("resave", 0, base_wr + 32, 60000);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | busy;
      end
      checkOutput("resave_quiet", 64'(seen), 64'd0);
      checkLbas("resave_lba", wr_lbas, base_wr, 32);
      checkOutput("resave_cap_cnt", 64'(cap_cnt - base_cap), 64'd16384);
      checkOutput("resave_cap", 64'(capErrors()), 64'd0);
      checkOutput("resave_dirty", 64'(dirty), 64'd0);

      // Reset in the middle of sector 3 of a load.
      base_rd  = rd_lbas.size();
      hps_salt = 8'h3C;
      applyStimulus(1'b1, 64'd8192, 1'b0, 1'b0);
      waitSector("rst_s3", 1'b1, base_rd + 4, 100, 10000);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort_rd", 64'(sd_rd), 64'd0);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_we", 64'(sram_b_we), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("abort_count", 64'(rd_lbas.size() - base_rd), 64'd4);
      checkOutput("abort_busy_after", 64'(busy), 64'd0);
      checkOutput("abort_dirty", 64'(dirty), 64'd0);
      checkOutput("abort_mem", 64'(memErrors()), 64'd0);
      checkOutput("abort_pin_600", 64'(mem[13'h0600]), 64'h3F);
      checkOutput("abort_pin_72c", 64'(mem[13'h072C]), 64'h2F);
      checkOutput("abort_pin_800", 64'(mem[13'h0800]), 64'h04);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
